// File: rtl/data_array_arbiter.sv
// data_array_arbiter
// Two-requester arbiter in front of a single-port, one-cycle-latency SRAM data array.
// Grants are combinational in the request cycle. Read data is returned on the winner's
// rvalid/rdata one cycle after the grant. Requester B can hold ownership across grants
// with b_lock.
//
// Build option: define DATA_ARB_ROUND_ROBIN_EN for round-robin contention in IDLE
// (the requester not granted most recently wins). When it is undefined, B always wins
// contention.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wmask/a_wdata   requester A access
//   a_gnt, a_rvalid, a_rdata       requester A grant and read response
//   b_req/b_we/b_addr/b_wmask/b_wdata/b_lock   requester B access (+ ownership lock)
//   b_gnt, b_rvalid, b_rdata       requester B grant and read response
//   sram_csb/web/wmask/addr/din    SRAM control (active-low select/write enable)
//   sram_dout                      SRAM read data (valid the cycle after a read)
//   busy                           lock held or read response in flight
module data_array_arbiter #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned NUM_WMASKS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [NUM_WMASKS-1:0] a_wmask,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [NUM_WMASKS-1:0] b_wmask,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   input  logic                  b_lock,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic [NUM_WMASKS-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout,
   output logic                  busy
);

   typedef enum logic {StIdle, StLockedB} state_e;

   state_e                  state_q, state_d;
   logic                    a_rvalid_q, b_rvalid_q;
   // sram_addr/sram_din keep their last driven value between grants
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   din_q;

`ifdef DATA_ARB_ROUND_ROBIN_EN
   // 1: B was granted most recently, so A wins the next contention
   logic last_b_q, last_b_d;
`endif

   // Arbitration and lock FSM
   always_comb begin
      a_gnt   = 1'b0;
      b_gnt   = 1'b0;
      state_d = state_q;
      if (!rst) begin
         unique case (state_q)
            StIdle: begin
               if (a_req && b_req) begin
`ifdef DATA_ARB_ROUND_ROBIN_EN
                  a_gnt = last_b_q;
                  b_gnt = ~last_b_q;
`else
                  b_gnt = 1'b1;
`endif
               end else begin
                  a_gnt = a_req;
                  b_gnt = b_req;
               end
            end
            StLockedB: begin
               b_gnt = b_req;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
         // Every B grant re-evaluates ownership from its own b_lock
         if (b_gnt) begin
            state_d = b_lock ? StLockedB : StIdle;
         end
      end
   end

`ifdef DATA_ARB_ROUND_ROBIN_EN
   always_comb begin
      last_b_d = last_b_q;
      if (b_gnt) begin
         last_b_d = 1'b1;
      end else if (a_gnt) begin
         last_b_d = 1'b0;
      end
   end
`endif

   // SRAM pin mux
   always_comb begin
      sram_csb   = 1'b1;
      sram_web   = 1'b1;
      sram_wmask = '0;
      sram_addr  = addr_q;
      sram_din   = din_q;
      if (a_gnt) begin
         sram_csb   = 1'b0;
         sram_web   = ~a_we;
         sram_wmask = a_we ? a_wmask : '0;
         sram_addr  = a_addr;
         sram_din   = a_wdata;
      end else if (b_gnt) begin
         sram_csb   = 1'b0;
         sram_web   = ~b_we;
         sram_wmask = b_we ? b_wmask : '0;
         sram_addr  = b_addr;
         sram_din   = b_wdata;
      end
      // Held values are stale until the reset edge clears them
      if (rst) begin
         sram_addr = '0;
         sram_din  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
`ifdef DATA_ARB_ROUND_ROBIN_EN
         last_b_q   <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         a_rvalid_q <= a_gnt & ~a_we;
         b_rvalid_q <= b_gnt & ~b_we;
         addr_q     <= sram_addr;
         din_q      <= sram_din;
`ifdef DATA_ARB_ROUND_ROBIN_EN
         last_b_q   <= last_b_d;
`endif
      end
   end

   // Gate with rst so a read granted just before reset never shows a response
   always_comb begin
      a_rvalid = a_rvalid_q & ~rst;
      b_rvalid = b_rvalid_q & ~rst;
      a_rdata  = a_rvalid ? sram_dout : '0;
      b_rdata  = b_rvalid ? sram_dout : '0;
      busy     = ~rst & ((state_q == StLockedB) | a_rvalid_q | b_rvalid_q);
   end

endmodule

// File: tb/tb_data_array_arbiter.sv
module tb_data_array_arbiter;

   localparam int AW = 4;
   localparam int DW = 256;
   localparam int NM = 32;

   logic          clk;
   logic          rst;
   logic          a_req, a_we, b_req, b_we, b_lock;
   logic [AW-1:0] a_addr, b_addr;
   logic [NM-1:0] a_wmask, b_wmask;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          sram_csb, sram_web;
   logic [NM-1:0] sram_wmask;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din, sram_dout;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit mon_en = 0;

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          a_q[$];
   exp_t          b_q[$];
   logic [DW-1:0] shadow [16];
   logic [DW-1:0] mem [16];
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_din;

   data_array_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .NUM_WMASKS(NM)
   ) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wmask(a_wmask), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wmask(b_wmask), .b_wdata(b_wdata),
      .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_line(int i);
      logic [DW-1:0] l;
      for (int j = 0; j < NM; j++) l[j*8 +: 8] = 8'((i * 37 + j * 5 + 1) & 255);
      return l;
   endfunction

   // Behavioural SRAM: synchronous write with byte enables, one-cycle read latency
   initial for (int i = 0; i < 16; i++) mem[i] = init_line(i);
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) begin
            for (int k = 0; k < NM; k++)
               if (sram_wmask[k]) mem[sram_addr][k*8 +: 8] <= sram_din[k*8 +: 8];
         end else begin
            sram_dout <= mem[sram_addr];
         end
      end
   end

   task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void apply_write(logic [AW-1:0] ad, logic [NM-1:0] m, logic [DW-1:0] d);
      for (int k = 0; k < NM; k++)
         if (m[k]) shadow[ad][k*8 +: 8] = d[k*8 +: 8];
   endfunction

   // Response monitor: pops the scoreboard in the expected cycle, otherwise expects silence
   always @(negedge clk) begin
      if (mon_en) begin
         if (a_q.size() > 0 && a_q[0].cyc == cyc) begin
            chk("a_rvalid", a_rvalid, 1);
            chk("a_rdata", a_rdata, a_q[0].data);
            a_q.delete(0);
         end else begin
            chk("a_rvalid_idle", a_rvalid, 0);
            chk("a_rdata_zero", a_rdata, 0);
         end
         if (b_q.size() > 0 && b_q[0].cyc == cyc) begin
            chk("b_rvalid", b_rvalid, 1);
            chk("b_rdata", b_rdata, b_q[0].data);
            b_q.delete(0);
         end else begin
            chk("b_rvalid_idle", b_rvalid, 0);
            chk("b_rdata_zero", b_rdata, 0);
         end
      end
   end

   task automatic set_a(logic r, logic w, logic [AW-1:0] ad, logic [NM-1:0] m,
                        logic [DW-1:0] d);
      a_req = r; a_we = w; a_addr = ad; a_wmask = m; a_wdata = d;
   endtask

   task automatic set_b(logic r, logic w, logic [AW-1:0] ad, logic [NM-1:0] m,
                        logic [DW-1:0] d, logic lk);
      b_req = r; b_we = w; b_addr = ad; b_wmask = m; b_wdata = d; b_lock = lk;
   endtask

   // One clock cycle: check grants, SRAM pins and busy mid-cycle, update the model
   task automatic cycle(string tag, bit ea, bit eb, bit ebusy);
      @(negedge clk);
      chk({tag, "_a_gnt"}, a_gnt, ea);
      chk({tag, "_b_gnt"}, b_gnt, eb);
      chk({tag, "_busy"}, busy, ebusy);
      if (ea) begin
         chk({tag, "_csb"}, sram_csb, 0);
         chk({tag, "_web"}, sram_web, !a_we);
         chk({tag, "_wmask"}, sram_wmask, a_we ? a_wmask : 32'h0);
         chk({tag, "_addr"}, sram_addr, a_addr);
         chk({tag, "_din"}, sram_din, a_wdata);
         if (a_we) apply_write(a_addr, a_wmask, a_wdata);
         else a_q.push_back('{cyc + 1, shadow[a_addr]});
         last_addr = a_addr;
         last_din  = a_wdata;
      end else if (eb) begin
         chk({tag, "_csb"}, sram_csb, 0);
         chk({tag, "_web"}, sram_web, !b_we);
         chk({tag, "_wmask"}, sram_wmask, b_we ? b_wmask : 32'h0);
         chk({tag, "_addr"}, sram_addr, b_addr);
         chk({tag, "_din"}, sram_din, b_wdata);
         if (b_we) apply_write(b_addr, b_wmask, b_wdata);
         else b_q.push_back('{cyc + 1, shadow[b_addr]});
         last_addr = b_addr;
         last_din  = b_wdata;
      end else begin
         chk({tag, "_csb_idle"}, sram_csb, 1);
         chk({tag, "_web_idle"}, sram_web, 1);
         chk({tag, "_wmask_idle"}, sram_wmask, 0);
         chk({tag, "_addr_hold"}, sram_addr, last_addr);
         chk({tag, "_din_hold"}, sram_din, last_din);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks(string tag);
      @(negedge clk);
      chk({tag, "_a_gnt"}, a_gnt, 0);
      chk({tag, "_b_gnt"}, b_gnt, 0);
      chk({tag, "_a_rvalid"}, a_rvalid, 0);
      chk({tag, "_b_rvalid"}, b_rvalid, 0);
      chk({tag, "_a_rdata"}, a_rdata, 0);
      chk({tag, "_b_rdata"}, b_rdata, 0);
      chk({tag, "_csb"}, sram_csb, 1);
      chk({tag, "_web"}, sram_web, 1);
      chk({tag, "_wmask"}, sram_wmask, 0);
      chk({tag, "_addr"}, sram_addr, 0);
      chk({tag, "_din"}, sram_din, 0);
      chk({tag, "_busy"}, busy, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit ea, eb;
      for (int i = 0; i < 16; i++) shadow[i] = init_line(i);
      last_addr = '0;
      last_din  = '0;
      rst = 1'b1;
      // Both requesters already asserting during reset; nothing may be granted
      set_a(1, 0, 4'd1, 32'h0, {8{32'h1111_2222}});
      set_b(1, 0, 4'd2, 32'h0, {8{32'h3333_4444}}, 0);
      @(posedge clk);
      #1;
      mon_en = 1;
      @(posedge clk);
      #1;
      reset_checks("rst0");
      rst = 1'b0;

      // Contention from the very first cycle after reset
      for (int i = 0; i < 4; i++) begin
`ifdef DATA_ARB_ROUND_ROBIN_EN
         ea = (i % 2 == 0);
         eb = !ea;
`else
         ea = 0;
         eb = 1;
`endif
         cycle($sformatf("contend%0d", i), ea, eb, i != 0);
      end
      set_a(0, 0, 4'd0, 32'h0, '0);
      set_b(0, 0, 4'd0, 32'h0, '0, 0);
      cycle("idle18", 0, 0, 1);

      // Masked write then read-back of the same line, back to back
      set_a(1, 1, 4'd3, 32'h0000_000F, {224'h0, 32'hDEAD_BEEF});
      cycle("w17", 1, 0, 0);
      set_a(1, 0, 4'd3, 32'h0, '0);
      cycle("r17", 1, 0, 0);
      set_a(0, 0, 4'd0, 32'h0, '0);
      @(negedge clk);
      chk("r17_low_word", a_rdata[31:0], 32'hDEAD_BEEF);
      @(posedge clk);
      #1;

      // Reads on alternate ports in consecutive cycles
      set_a(1, 0, 4'd7, 32'h0, '0);
      cycle("a21", 1, 0, 0);
      set_a(0, 0, 4'd0, 32'h0, '0);
      set_b(1, 0, 4'd8, 32'h0, '0, 0);
      cycle("b21", 0, 1, 1);
      set_b(0, 0, 4'd0, 32'h0, '0, 0);
      cycle("idle21a", 0, 0, 1);
      cycle("idle21b", 0, 0, 0);

      // B lock: A held off until after B's unlocking write
      set_b(1, 0, 4'd5, 32'h0, '0, 1);
      cycle("b19lock", 0, 1, 0);
      set_b(0, 0, 4'd0, 32'h0, '0, 0);
      set_a(1, 0, 4'd5, 32'h0, '0);
      cycle("a19blocked", 0, 0, 1);
      set_b(1, 1, 4'd5, 32'hF000_0000, {8{32'hCAFE_F00D}}, 0);
      cycle("b19unlock", 0, 1, 1);
      set_b(0, 0, 4'd0, 32'h0, '0, 0);
      cycle("a19", 1, 0, 0);
      set_a(0, 0, 4'd0, 32'h0, '0);
      cycle("idle19", 0, 0, 1);

      // Read granted, then reset: the response must be dropped
      set_a(1, 0, 4'd4, 32'h0, {8{32'h5A5A_A5A5}});
      cycle("a20", 1, 0, 0);
      rst = 1'b1;
      a_q.delete();
      set_b(1, 0, 4'd9, 32'h0, '0, 0);
      reset_checks("rst20");
      rst = 1'b0;
      last_addr = '0;
      last_din  = '0;
`ifdef DATA_ARB_ROUND_ROBIN_EN
      cycle("post20", 1, 0, 0);
`else
      cycle("post20", 0, 1, 0);
`endif
      set_a(0, 0, 4'd0, 32'h0, '0);
      set_b(0, 0, 4'd0, 32'h0, '0, 0);
      cycle("end0", 0, 0, 1);
      cycle("end1", 0, 0, 0);
      chk("a_q_drained", a_q.size(), 0);
      chk("b_q_drained", b_q.size(), 0);

      mon_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/data_array_arbiter.md
DATA_ARRAY_ARBITER -- requirements
Module: data_array_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 4, line index width; DATA_WIDTH, default 256, line width in bits; NUM_WMASKS, default 32, byte-enable count (DATA_WIDTH/8).
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- a_req  in  1  requester A access request
- a_we  in  1  A write (1) / read (0)
- a_addr  in  ADDR_WIDTH  A line index
- a_wmask  in  NUM_WMASKS  A byte enables
- a_wdata  in  DATA_WIDTH  A write data
- a_gnt  out  1  A request accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  DATA_WIDTH  A read data
- b_req, b_we, b_addr, b_wmask, b_wdata  in  as for A  requester B request
- b_lock  in  1  B keeps ownership after this grant
- b_gnt, b_rvalid, b_rdata  out  as for A  B responses
- sram_csb  out  1  SRAM chip select, active low
- sram_web  out  1  SRAM write enable, active low
- sram_wmask  out  NUM_WMASKS  SRAM byte enables
- sram_addr  out  ADDR_WIDTH  SRAM line index
- sram_din  out  DATA_WIDTH  SRAM write data
- sram_dout  in  DATA_WIDTH  SRAM read data
- busy  out  1  lock held or read response pending

Function
REQ-003 Grants SHALL be combinational in the request cycle. At most one of a_gnt/b_gnt SHALL be high per cycle.
REQ-004 A requester SHALL hold req and all request fields stable until its gnt. gnt SHALL be high only while the matching req is high.
REQ-005 In a grant cycle, the SRAM pins SHALL be driven combinationally from the winner:
- sram_csb=0, sram_web=~we, sram_addr=addr, sram_din=wdata
- sram_wmask=wmask for writes, all-zero for reads
REQ-006 Without a grant: sram_csb=1, sram_web=1, sram_wmask=0. sram_addr and sram_din SHALL hold the last driven values.
REQ-007 A read granted in cycle N SHALL assert the winner's rvalid for exactly cycle N+1. A write SHALL produce no rvalid.
REQ-008 x_rdata SHALL equal sram_dout while x_rvalid=1 and SHALL be zero otherwise.
REQ-009 Back-to-back grants SHALL be allowed every cycle, including alternating requesters and a write followed by a read to the same address.
REQ-010 FSM states SHALL be IDLE and LOCKED_B.
- IDLE -> LOCKED_B when B is granted with b_lock=1.
- LOCKED_B -> IDLE when B is granted with b_lock=0.
- In LOCKED_B, A SHALL never be granted; B is granted whenever b_req=1.
REQ-011 In IDLE with only one req high, that requester SHALL be granted. Contention is resolved per REQ-016.
REQ-012 busy SHALL be 1 in LOCKED_B or in any cycle where an rvalid is high.

Reset
REQ-013 While rst=1, the following SHALL hold:
- a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0
- sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0, busy=0
- state=IDLE; round-robin pointer set so that A wins the first contention
REQ-014 A read granted in the cycle before rst rises SHALL produce no rvalid after reset.
REQ-015 The first grant SHALL be possible in the first cycle with rst=0.

Configuration
REQ-016 Macro DATA_ARB_ROUND_ROBIN_EN SHALL select the IDLE contention policy.
- Defined: the requester not granted most recently wins. The pointer updates on every grant, including grants in LOCKED_B.
- Undefined: B always wins contention and no pointer state exists.
- REQ-010 lock behaviour SHALL be identical in both builds.

Verification
REQ-017 A write, addr=3, wmask=0x0000000F, wdata low word 0xDEADBEEF; then A read, addr=3 -> a_gnt both cycles; a_rvalid one cycle after the read; a_rdata[31:0]=0xDEADBEEF; other bytes keep prior contents.
REQ-018 A and B read simultaneously, addr 1 and 2, held high for 4 cycles -> with macro: grants alternate A,B,A,B; without macro: B,B,B,B and A starved.
REQ-019 B read addr=5 with b_lock=1, then B write addr=5 with b_lock=0 while a_req held high -> A is not granted until the cycle after the B write grant; busy=1 throughout.
REQ-020 A read granted, rst asserted the next cycle -> a_rvalid stays 0; all outputs match REQ-013.
REQ-021 A read addr=7 in cycle N, B read addr=8 in cycle N+1 -> a_rvalid in N+1 only, b_rvalid in N+2 only, each with the correct line data and zero rdata on the other port.
